// File: rtl/regfile_pkg.sv
// Shared widths and encodings for the MIPS general-purpose register file.
package regfile_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 32;
  localparam int READ_PORTS   = 2;

  typedef logic [REG_BUS-1:0]      word_t;
  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  localparam logic      RST_ENABLE   = 1'b0;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;
  localparam word_t     ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset, $0, same-cycle bypass, then storage.
module regfile_rdport
  import regfile_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  word_t     mem_data,
  output word_t     rdata
);

  // The bypass compare runs beside the array read; only the final mux joins them.
  always_comb begin
    rdata = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      rdata = ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      rdata = ZERO_WORD;
    end else if (re == READ_ENABLE && we == WRITE_ENABLE && raddr == waddr) begin
      rdata = wdata;
    end else if (re == READ_ENABLE) begin
      rdata = mem_data;
    end else begin
      rdata = ZERO_WORD;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: one write port from write-back, two bypassed read ports.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output word_t     rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output word_t     rdata2
);

  word_t regs [REG_NUM];

  // Clearing is asynchronous so decode sees zeros without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

  logic      re_vec    [READ_PORTS];
  reg_addr_t raddr_vec [READ_PORTS];
  word_t     rdata_vec [READ_PORTS];

  assign re_vec[0]    = re1;
  assign re_vec[1]    = re2;
  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;
  assign rdata1       = rdata_vec[0];
  assign rdata2       = rdata_vec[1];

  generate
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rdport
      regfile_rdport u_rdport (
        .rst      (rst),
        .re       (re_vec[gi]),
        .raddr    (raddr_vec[gi]),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .mem_data (regs[raddr_vec[gi]]),
        .rdata    (rdata_vec[gi])
      );
    end
  endgenerate

endmodule
